bram_capture_ctrl: RTL and testbench
====================================

Name: bram_capture_ctrl

Overview:
- Sequences a single simple-dual-port block RAM as a sample capture buffer for the comm-system debug path.
- Capture phase: writes a valid-qualified sample stream into consecutive RAM addresses until the RAM is full or capture is stopped.
- Readout phase: serves random-access read requests through a fixed-latency request/response handshake.
- Sits between the datapath tap (e.g. filter/slicer output) and the host/VIO/UART readout logic; owns all RAM address, enable and reset pins.

Parameters:
- DATA_WIDTH, 32, sample and RAM word width.
- ADDR_WIDTH, 15, RAM address width; depth = 2**ADDR_WIDTH.
- RD_LATENCY, 2, RAM read latency in clocks: 2 with output register, 1 without.

Ports:
- clk  in  1  system clock
- i_reset  in  1  synchronous active-high reset; also driven out to RAM reset
- i_start  in  1  pulse: clear count, begin capture
- i_stop  in  1  pulse: end capture early
- i_data  in  DATA_WIDTH  sample to capture
- i_valid  in  1  sample qualifier
- i_rd_req  in  1  read request
- i_rd_addr  in  ADDR_WIDTH  read address
- o_rd_ready  out  1  request accepted when i_rd_req&&o_rd_ready
- o_rd_data  out  DATA_WIDTH  read response data
- o_rd_valid  out  1  response strobe
- o_busy  out  1  high in CAPTURE
- o_done  out  1  high in DONE
- o_count  out  ADDR_WIDTH+1  samples captured (0..2**ADDR_WIDTH)
- o_addr_err  out  1  sticky: out-of-range read request seen
- o_ram_wr_addr, o_ram_rd_addr  out  ADDR_WIDTH  RAM addresses
- o_ram_wr_data  out  DATA_WIDTH  RAM write data (= i_data)
- o_ram_wr_en, o_ram_rd_en  out  1  RAM enables
- o_ram_reset  out  1  = i_reset
- i_ram_data  in  DATA_WIDTH  RAM read data

Behaviour:
- Clocking/reset: one clock (clk); reset i_reset is synchronous, active-high.
- Reset values: state IDLE; wr_ptr=0, o_count=0; valid pipe cleared; o_rd_valid=0, o_busy=0, o_done=0, o_addr_err=0, o_rd_ready=0. RAM contents are not cleared.
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - i_start -> CAPTURE; wr_ptr=0, count=0, o_addr_err cleared.
  - Read requests are not accepted.
- CAPTURE:
  - o_ram_wr_en = i_valid (combinational); o_ram_wr_addr = wr_ptr.
  - Each i_valid increments wr_ptr and count.
  - The write that makes count = 2**ADDR_WIDTH -> DONE on the same edge; wr_ptr wraps to 0 but no further write occurs.
  - i_stop -> DONE. A sample valid in the same cycle is written and counted.
  - i_start while in CAPTURE restarts: count=0, wr_ptr=0; a sample valid that cycle is written to address 0 with count=1.
  - o_rd_ready=0.
- DONE:
  - o_rd_ready=1.
  - On accept: o_ram_rd_en=1, o_ram_rd_addr=i_rd_addr (combinational, same cycle).
  - Accept at edge N -> o_rd_valid=1 exactly at edge N+RD_LATENCY, with o_rd_data=i_ram_data.
  - One request per cycle, fully pipelined; responses are returned in order.
  - i_rd_addr >= count: request consumed, no RAM read, no response; o_addr_err set (sticky until i_start or reset).
  - i_start -> CAPTURE. A simultaneous i_rd_req is not accepted (o_rd_ready=0 that cycle). Already-accepted responses still drain from the pipe.
- o_ram_rd_en=0 and o_ram_wr_en=0 whenever not explicitly asserted above.
- Simultaneous i_start and i_stop: i_start wins.
- Reset mid-capture or mid-readout: everything returns to reset values on the next edge; in-flight responses are discarded.

Decomposition:
- Shared package bram_capture_pkg: state encoding (ST_IDLE=2'd0, ST_CAPTURE=2'd1, ST_DONE=2'd2) and the DEPTH localparam derived from ADDR_WIDTH.
- One sub-module: valid_delay_line (RD_LATENCY-deep shift register with synchronous clear), generating o_rd_valid.
- bram_capture_ctrl holds the FSM, pointers and error flag; the RAM is instantiated beside it at top level, not inside it.

Test Plan (ADDR_WIDTH=4, DATA_WIDTH=16, RD_LATENCY=2, RAM with output register):
- Full capture: i_start, then 16 valids of data 0xA000+k -> o_done high after 16th write, o_count=16, a 17th valid causes no write; reading addr 5 returns 0xA005 with o_rd_valid two edges after accept.
- Gapped input plus early stop: valids only on odd cycles for 6 samples, then i_stop -> o_count=6, addresses 0..5 hold those samples in order.
- Back-to-back reads: requests to addr 0,1,2,3 on consecutive cycles -> four consecutive o_rd_valid pulses carrying the correct data in order.
- Out-of-range read: count=6, request addr 9 -> no o_rd_valid, o_addr_err=1; a later i_start clears it.
- i_start in DONE with a simultaneous request, and a request accepted one cycle earlier -> the earlier response is still delivered; the simultaneous request is not accepted; state=CAPTURE and o_count=0.
- Reset asserted mid-capture after 7 samples -> next edge: o_busy=0, o_count=0, o_rd_valid=0; a new capture starts writing at address 0.

Source files
------------

// File: rtl/bram_capture_pkg.sv
// Shared definitions for the BRAM capture controller: FSM encoding and depth helpers.
package bram_capture_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam int DEF_ADDR_WIDTH = 15;
    localparam int DEF_DEPTH      = 2 ** DEF_ADDR_WIDTH;

    function automatic int depth_of(input int aw);
        return 2 ** aw;
    endfunction
endpackage

// File: rtl/bram_capture_ctrl_valid_delay_line.sv
// Fixed-latency shift register that tracks accepted reads until RAM data is on the bus.
module valid_delay_line #(
    parameter int LATENCY = 2
) (
    input  logic clk,
    input  logic i_clr,
    input  logic i_d,
    output logic o_q
);
    logic [LATENCY-1:0] vld_pipe_q;

    always_ff @(posedge clk) begin
        if (i_clr) vld_pipe_q <= '0;
        else       vld_pipe_q <= (vld_pipe_q << 1) | LATENCY'(i_d);
    end

    assign o_q = vld_pipe_q[LATENCY-1];
endmodule

// File: rtl/bram_capture_ctrl.sv
// Capture/readout sequencer for one simple-dual-port BRAM used as a debug sample buffer.
module bram_capture_ctrl
    import bram_capture_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  i_reset,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    input  logic                  i_rd_req,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic                  o_rd_ready,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH:0]   o_count,
    output logic                  o_addr_err,
    output logic [ADDR_WIDTH-1:0] o_ram_wr_addr,
    output logic [ADDR_WIDTH-1:0] o_ram_rd_addr,
    output logic [DATA_WIDTH-1:0] o_ram_wr_data,
    output logic                  o_ram_wr_en,
    output logic                  o_ram_rd_en,
    output logic                  o_ram_reset,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);
    localparam int                DEPTH    = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH+1)'(DEPTH - 1);

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  err_q;
    logic                  accept;
    logic                  in_range;

    // Enables are gated by reset so nothing touches the RAM on the reset edge.
    assign o_rd_ready    = (state_q == ST_DONE) && !i_start && !i_reset;
    assign accept        = o_rd_ready && i_rd_req;
    assign in_range      = ({1'b0, i_rd_addr} < count_q);
    assign o_ram_rd_en   = accept && in_range;
    assign o_ram_rd_addr = i_rd_addr;
    assign o_ram_wr_en   = (state_q == ST_CAPTURE) && i_valid && !i_reset;
    assign o_ram_wr_addr = i_start ? '0 : wr_ptr_q;
    assign o_ram_wr_data = i_data;
    assign o_ram_reset   = i_reset;
    assign o_rd_data     = i_ram_data;
    assign o_busy        = (state_q == ST_CAPTURE);
    assign o_done        = (state_q == ST_DONE);
    assign o_count       = count_q;
    assign o_addr_err    = err_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= ST_IDLE;
            wr_ptr_q <= '0;
            count_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (i_start) begin
                        state_q  <= ST_CAPTURE;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                        err_q    <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (i_start) begin
                        // Restart: a sample valid this cycle lands at address 0.
                        wr_ptr_q <= ADDR_WIDTH'(i_valid);
                        count_q  <= (ADDR_WIDTH+1)'(i_valid);
                    end else begin
                        if (i_valid) begin
                            wr_ptr_q <= wr_ptr_q + 1'b1;
                            count_q  <= count_q + 1'b1;
                        end
                        if ((i_valid && count_q == LAST_CNT) || i_stop)
                            state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (i_start) begin
                        state_q  <= ST_CAPTURE;
                        wr_ptr_q <= '0;
                        count_q  <= '0;
                        err_q    <= 1'b0;
                    end else if (accept && !in_range) begin
                        err_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    valid_delay_line #(.LATENCY(RD_LATENCY)) u_vld (
        .clk   (clk),
        .i_clr (i_reset),
        .i_d   (o_ram_rd_en),
        .o_q   (o_rd_valid)
    );
endmodule

// File: tb/tb_bram_capture_ctrl.sv
// Randomized bench for bram_capture_ctrl against a transaction-level capture/readout model.
module tb_bram_capture_ctrl;
    localparam int DW = 16, AW = 4, LAT = 2, DEPTH = 16;

    logic          clk = 1'b0;
    logic          i_reset = 1'b1, i_start = 1'b0, i_stop = 1'b0, i_valid = 1'b0, i_rd_req = 1'b0;
    logic [DW-1:0] i_data = '0, i_ram_data;
    logic [AW-1:0] i_rd_addr = '0;
    logic          o_rd_ready, o_rd_valid, o_busy, o_done, o_addr_err;
    logic          o_ram_wr_en, o_ram_rd_en, o_ram_reset;
    logic [DW-1:0] o_rd_data, o_ram_wr_data;
    logic [AW:0]   o_count;
    logic [AW-1:0] o_ram_wr_addr, o_ram_rd_addr;

    always #5 clk = ~clk;

    bram_capture_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .i_reset(i_reset), .i_start(i_start), .i_stop(i_stop),
        .i_data(i_data), .i_valid(i_valid), .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
        .o_rd_ready(o_rd_ready), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .o_busy(o_busy), .o_done(o_done), .o_count(o_count), .o_addr_err(o_addr_err),
        .o_ram_wr_addr(o_ram_wr_addr), .o_ram_rd_addr(o_ram_rd_addr),
        .o_ram_wr_data(o_ram_wr_data), .o_ram_wr_en(o_ram_wr_en), .o_ram_rd_en(o_ram_rd_en),
        .o_ram_reset(o_ram_reset), .i_ram_data(i_ram_data)
    );

    // Simple-dual-port RAM with output register (two-clock read).
    logic [DW-1:0] ram [DEPTH];
    logic [DW-1:0] ram_r1, ram_r2;
    always @(posedge clk) begin
        if (o_ram_wr_en) ram[o_ram_wr_addr] <= o_ram_wr_data;
        if (o_ram_rd_en) ram_r1 <= ram[o_ram_rd_addr];
        ram_r2 <= ram_r1;
    end
    assign i_ram_data = ram_r2;

    int checks = 0, errors = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Reference model: capture buffer contents, sample count and pending responses.
    typedef struct { int due; logic [DW-1:0] d; } resp_t;
    resp_t         pend[$];
    bit            m_cap, m_done, m_err;
    int            m_cnt;
    logic [DW-1:0] m_mem [DEPTH];

    task automatic tick(input bit rst, input bit st, input bit sp, input bit v,
                        input logic [DW-1:0] d, input bit rq, input logic [AW-1:0] a);
        bit exp_rv, rdy, acc, inr, wen;
        resp_t r;
        chk("busy", o_busy, m_cap);
        chk("done", o_done, m_done);
        chk("count", o_count, m_cnt);
        chk("addr_err", o_addr_err, m_err);
        exp_rv = (pend.size() > 0) && (pend[0].due == cyc + 1);
        chk("rd_valid", o_rd_valid, exp_rv);
        if (exp_rv) begin
            chk("rd_data", o_rd_data, pend[0].d);
            void'(pend.pop_front());
        end
        i_reset = rst; i_start = st; i_stop = sp; i_valid = v; i_data = d;
        i_rd_req = rq; i_rd_addr = a;
        #1;
        rdy = m_done && !st && !rst;
        acc = rdy && rq;
        inr = (int'(a) < m_cnt);
        wen = m_cap && v && !rst;
        chk("rd_ready", o_rd_ready, rdy);
        chk("wr_en", o_ram_wr_en, wen);
        if (wen) begin
            chk("wr_addr", o_ram_wr_addr, st ? 0 : m_cnt % DEPTH);
            chk("wr_data", o_ram_wr_data, d);
        end
        chk("rd_en", o_ram_rd_en, acc && inr);
        if (acc && inr) chk("rd_addr", o_ram_rd_addr, a);
        chk("ram_reset", o_ram_reset, rst);
        if (rst) begin
            m_cap = 0; m_done = 0; m_cnt = 0; m_err = 0; pend.delete();
        end else if (m_cap) begin
            if (st) begin
                m_cnt = 0;
                if (v) begin m_mem[0] = d; m_cnt = 1; end
            end else begin
                if (v) begin m_mem[m_cnt % DEPTH] = d; m_cnt++; end
                if (m_cnt == DEPTH || sp) begin m_cap = 0; m_done = 1; end
            end
        end else if (m_done) begin
            if (st) begin
                m_done = 0; m_cap = 1; m_cnt = 0; m_err = 0;
            end else if (acc) begin
                if (inr) begin r.due = cyc + 1 + LAT; r.d = m_mem[a]; pend.push_back(r); end
                else m_err = 1;
            end
        end else if (st) begin
            m_cap = 1; m_cnt = 0; m_err = 0;
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 0, '0, 0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a);
        tick(0, 0, 0, 0, '0, 1, a);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        cyc = 2;
        @(negedge clk);
        m_cap = 0; m_done = 0; m_cnt = 0; m_err = 0;
        tick(1, 0, 0, 0, '0, 0, '0);
        idle(2);

        // Full capture of 16 samples, then an extra valid that must not write.
        tick(0, 1, 0, 0, '0, 0, '0);
        for (int k = 0; k < DEPTH; k++) tick(0, 0, 0, 1, DW'(16'hA000 + k), 0, '0);
        tick(0, 0, 0, 1, 16'hBEEF, 0, '0);
        rd(4'd5);
        idle(3);

        // Gapped capture (valid on odd cycles), early stop after 6 samples.
        tick(0, 1, 0, 0, '0, 0, '0);
        for (int k = 0; k < 12; k++) tick(0, 0, 0, k % 2 == 1, DW'($urandom), 0, '0);
        tick(0, 0, 1, 0, '0, 0, '0);
        for (int k = 0; k < 6; k++) rd(AW'(k));
        idle(3);

        // Out-of-range read, then restart clears the error.
        rd(4'd9);
        idle(3);
        tick(0, 1, 0, 0, '0, 0, '0);
        for (int k = 0; k < 5; k++) tick(0, 0, 0, 1, DW'($urandom), 0, '0);
        tick(0, 0, 1, 1, DW'($urandom), 0, '0);

        // Start in DONE with a simultaneous request behind an accepted one.
        rd(4'd1);
        tick(0, 1, 0, 0, '0, 1, 4'd2);
        idle(3);

        // Reset mid-capture after 7 samples, then a fresh capture from address 0.
        for (int k = 0; k < 7; k++) tick(0, 0, 0, 1, DW'($urandom), 0, '0);
        tick(1, 0, 0, 0, '0, 0, '0);
        tick(0, 1, 0, 0, '0, 0, '0);
        for (int k = 0; k < 3; k++) tick(0, 0, 0, 1, DW'($urandom), 0, '0);
        tick(0, 0, 1, 0, '0, 0, '0);
        for (int k = 0; k < 3; k++) rd(AW'(k));
        idle(3);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            tick($urandom_range(0, 63) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1, DW'($urandom),
                 $urandom_range(0, 1) == 1, AW'($urandom));
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
